// File: rtl/sl_pkg.sv
// Shared constants for the SL-line transmitter: line codes, one-hot state
// indices and a bit encoder used by the transmit FSM.
package sl_pkg;

  typedef logic [1:0] sl_code_t;

  // Line codes, ordered {SL0,SL1}
  localparam sl_code_t SL_IDLE = 2'b11;
  localparam sl_code_t SL_ONE  = 2'b10;
  localparam sl_code_t SL_ZERO = 2'b01;
  localparam sl_code_t SL_STOP = 2'b00;

  // Bit positions of the one-hot state vector
  localparam int IDLE   = 0;
  localparam int LOAD   = 1;
  localparam int DATA   = 2;
  localparam int GAP    = 3;
  localparam int PARITY = 4;
  localparam int STOP   = 5;
  localparam int END    = 6;
  localparam int NSTATE = 7;

  localparam logic [NSTATE-1:0] S_IDLE   = 7'b0000001;
  localparam logic [NSTATE-1:0] S_LOAD   = 7'b0000010;
  localparam logic [NSTATE-1:0] S_DATA   = 7'b0000100;
  localparam logic [NSTATE-1:0] S_GAP    = 7'b0001000;
  localparam logic [NSTATE-1:0] S_PARITY = 7'b0010000;
  localparam logic [NSTATE-1:0] S_STOP   = 7'b0100000;
  localparam logic [NSTATE-1:0] S_END    = 7'b1000000;

  // Data and parity bits share the same line encoding
  function automatic sl_code_t sl_encode_bit(input logic b);
    return b ? SL_ONE : SL_ZERO;
  endfunction

endpackage

// File: rtl/sl_tx_fifo.sv
// Word queue in front of the SL transmitter. Pointers carry an extra MSB so
// full and empty are told apart without a separate counter. All status
// outputs are registered.
module sl_tx_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     overflow_o
);
  import sl_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [AW:0]       level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  // A pop frees a slot in the same cycle, so a push at full still fits;
  // flush wins over a push and silently drops it.
  assign do_pop  = pop_i && !empty_q;
  assign do_push = push_i && !flush_i && (!full_q || do_pop);

  // Next pointer values and the status they imply
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
    end
    level_d = wptr_d - rptr_d;
    empty_d = (wptr_d == rptr_d);
    full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    ovf_d   = push_i && !flush_i && full_q && !do_pop;
  end

  // Pointer and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array; contents need no reset since the pointers gate all reads
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o    = mem_q[rptr_q[AW-1:0]];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign level_o    = level_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/sl_tx_buffered.sv
// Buffered SL-line transmitter: queues words in sl_tx_fifo and serialises
// each one as LSB-first data bits, a parity bit and a stop sequence, with
// every phase lasting cfg_div+1 clocks.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | line 11, idle guard counting down, waiting for a queued word
// LOAD   | pop FIFO head, latch data, length, parity mode and phase length
// DATA   | drive current data bit (10 = one, 01 = zero)
// GAP    | line 11 between bits
// PARITY | drive parity bit, encoded like a data bit
// STOP   | line 00
// END    | line 11, word completes at the end of this phase
module sl_tx_buffered #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4,
  parameter int DIV_W      = 8,
  parameter int GAP_PHASES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   SL0,
  output logic                   SL1,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   wr_en,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   flush,
  input  logic                   enable,
  input  logic [5:0]             cfg_len,
  input  logic                   cfg_odd,
  input  logic [DIV_W-1:0]       cfg_div,
  output logic                   busy,
  output logic                   word_done
);
  import sl_pkg::*;

  localparam int NW = $clog2(DATA_W + 1);
  // Wide enough to hold GAP_PHASES * 2^DIV_W
  localparam int GW = DIV_W + $clog2(GAP_PHASES + 1);

  logic [NSTATE-1:0] state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [NW-1:0]     n_q, n_d;
  logic [NW-1:0]     bitcnt_q, bitcnt_d;
  logic              odd_q, odd_d;
  logic              par_q, par_d;
  logic              par_sent_q, par_sent_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DIV_W-1:0]  phase_q, phase_d;
  logic [GW-1:0]     guard_q, guard_d;
  sl_code_t          sl_q, sl_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              fifo_pop;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              phase_end;
  logic [NW-1:0]     len_eff;
  logic [GW-1:0]     guard_load;

  sl_tx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (wr_en),
    .pop_i      (fifo_pop),
    .flush_i    (flush),
    .wdata_i    (wr_data),
    .rdata_o    (fifo_rdata),
    .full_o     (full),
    .empty_o    (fifo_empty),
    .level_o    (level),
    .overflow_o (overflow)
  );

  assign phase_end  = (phase_q == div_q);
  assign guard_load = GW'(GAP_PHASES) * (GW'(div_q) + GW'(1));

  // Out-of-range lengths fall back to the full word width
  always_comb begin
    if (cfg_len == 6'd0 || int'(cfg_len) > DATA_W) len_eff = NW'(DATA_W);
    else                                           len_eff = NW'(cfg_len);
  end

  // State transitions; LOAD is the only state that pops the queue
  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    if (state_q[IDLE]) begin
      if (enable && !fifo_empty && guard_q == '0) state_d = S_LOAD;
    end else if (state_q[LOAD]) begin
      fifo_pop = 1'b1;
      state_d  = S_DATA;
    end else if (state_q[DATA]) begin
      if (phase_end) state_d = S_GAP;
    end else if (state_q[GAP]) begin
      if (phase_end) begin
        if (bitcnt_q < n_q)   state_d = S_DATA;
        else if (!par_sent_q) state_d = S_PARITY;
        else                  state_d = S_STOP;
      end
    end else if (state_q[PARITY]) begin
      if (phase_end) state_d = S_GAP;
    end else if (state_q[STOP]) begin
      if (phase_end) state_d = S_END;
    end else if (state_q[END]) begin
      if (phase_end) state_d = S_IDLE;
    end else begin
      state_d = S_IDLE;
    end
  end

  // Word datapath: latched config, shift register, bit counter, parity
  // accumulator, phase counter and post-word idle guard
  always_comb begin
    sh_d       = sh_q;
    n_d        = n_q;
    odd_d      = odd_q;
    div_d      = div_q;
    bitcnt_d   = bitcnt_q;
    par_d      = par_q;
    par_sent_d = par_sent_q;
    guard_d    = guard_q;

    if (state_q[LOAD]) begin
      sh_d       = fifo_rdata;
      n_d        = len_eff;
      odd_d      = cfg_odd;
      div_d      = cfg_div;
      bitcnt_d   = '0;
      par_d      = 1'b0;
      par_sent_d = 1'b0;
    end

    // Advance to the next bit only once the bit's phase has been sent
    if (state_q[DATA] && phase_end) begin
      sh_d     = sh_q >> 1;
      bitcnt_d = bitcnt_q + 1'b1;
      par_d    = par_q ^ sh_q[0];
    end

    if (state_q[PARITY]) par_sent_d = 1'b1;

    if (state_q[IDLE] || state_q[LOAD] || phase_end) phase_d = '0;
    else                                             phase_d = phase_q + 1'b1;

    if (state_q[END] && phase_end)              guard_d = guard_load;
    else if (state_q[IDLE] && guard_q != '0)    guard_d = guard_q - 1'b1;
  end

  // Output values follow the state being entered so the line is registered
  always_comb begin
    busy_d = |(state_d & (S_DATA | S_GAP | S_PARITY | S_STOP | S_END));
    done_d = state_q[END] && phase_end;
    if (state_d[DATA])        sl_d = sl_encode_bit(sh_d[0]);
    else if (state_d[PARITY]) sl_d = sl_encode_bit(par_q ^ odd_q);
    else if (state_d[STOP])   sl_d = SL_STOP;
    else                      sl_d = SL_IDLE;
  end

  // All FSM, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      n_q        <= '0;
      odd_q      <= 1'b0;
      div_q      <= '0;
      bitcnt_q   <= '0;
      par_q      <= 1'b0;
      par_sent_q <= 1'b0;
      phase_q    <= '0;
      guard_q    <= '0;
      sl_q       <= SL_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      n_q        <= n_d;
      odd_q      <= odd_d;
      div_q      <= div_d;
      bitcnt_q   <= bitcnt_d;
      par_q      <= par_d;
      par_sent_q <= par_sent_d;
      phase_q    <= phase_d;
      guard_q    <= guard_d;
      sl_q       <= sl_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign SL0       = sl_q[1];
  assign SL1       = sl_q[0];
  assign busy      = busy_q;
  assign word_done = done_q;

endmodule
